fp_add_scheduler: RTL

FP_ADD_SCHEDULER -- requirements
Module: fp_add_scheduler

---
 rtl/fp_add_scheduler_pkg.sv | 30 +++
 rtl/fp_add_scheduler_rsp_fifo.sv | 46 ++++
 rtl/fp_add_scheduler.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/fp_add_scheduler_pkg.sv
// Shared definitions for the fp add scheduler: opcodes, response tag and opcode legality.
package fp_add_scheduler_pkg;

    localparam int unsigned OPCODE_W = 4;
    localparam int unsigned TAG_ID_W = 8;

    typedef enum logic [OPCODE_W-1:0] {
        OP_ADD    = 4'd0,
        OP_SUB    = 4'd1,
        OP_MAXMIN = 4'd2,
        OP_FLOOR  = 4'd8,
        OP_CEIL   = 4'd9,
        OP_NOP    = 4'd15
    } fp_op_e;

    // Tag travelling alongside an op while it is inside the fp pipe.
    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
        logic                err;
    } rsp_tag_t;

    function automatic logic op_legal(input logic [OPCODE_W-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_MAXMIN, OP_FLOOR, OP_CEIL: return 1'b1;
            default:                                      return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/fp_add_scheduler_rsp_fifo.sv
// Response FIFO: circular buffer with occupancy count; push and pop may share an edge.
module fp_rsp_fifo #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned ENTRY_W = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [ENTRY_W-1:0]           push_data,
    input  logic                         pop,
    output logic [ENTRY_W-1:0]           head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;

    // Storage is data-only; validity comes from the count.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
            if (pop)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/fp_add_scheduler.sv
// Round-robin, credit-limited scheduler that shares one fp add pipe between requesters
// and returns results in issue order through a response FIFO.
module fp_add_scheduler
    import fp_add_scheduler_pkg::*;
#(
    parameter int unsigned WIDTH      = 24,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned LATENCY    = 3,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]     req_a,
    input  logic [NUM_REQ*WIDTH-1:0]     req_b,
    input  logic [NUM_REQ*4-1:0]         req_op,
    output logic [WIDTH-1:0]             pipe_a,
    output logic [WIDTH-1:0]             pipe_b,
    output logic [3:0]                   pipe_op,
    input  logic [WIDTH-1:0]             pipe_result,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
    output logic [WIDTH-1:0]             rsp_data,
    output logic                         rsp_err,
    output logic                         busy
);
    localparam int unsigned ID_W    = $clog2(NUM_REQ);
    localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH+1);
    localparam int unsigned SUM_W   = CNT_W + 1;
    localparam int unsigned ENTRY_W = ID_W + 1 + WIDTH;

    logic              started;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   grant_id;
    logic [ID_W-1:0]   idx;
    logic              grant_valid;
    logic              credit_ok;
    logic              issue;
    logic              push;
    logic              pop;
    logic              fifo_empty;
    logic [CNT_W-1:0]  inflight;
    logic [CNT_W-1:0]  fifo_count;
    logic [ENTRY_W-1:0] push_data;
    logic [ENTRY_W-1:0] head;
    rsp_tag_t          tag_q [LATENCY];
    rsp_tag_t          tag_last;
    logic              unused_tag_id;

    // Round-robin search starting at rr_ptr.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = '0;
        idx         = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = ID_W'((32'(rr_ptr) + k) % NUM_REQ);
            if (!grant_valid && req_valid[idx]) begin
                grant_valid = 1'b1;
                grant_id    = idx;
            end
        end
    end

    // A pop on this edge frees its slot, which lets back-to-back issue reach one per cycle.
    assign credit_ok = ({1'b0, inflight} + {1'b0, fifo_count}) < (SUM_W'(FIFO_DEPTH) + SUM_W'(pop));
    assign issue     = started && grant_valid && credit_ok;

    always_comb begin
        req_ready = '0;
        pipe_a    = '0;
        pipe_b    = '0;
        pipe_op   = 4'(OP_NOP);
        if (issue) begin
            req_ready[grant_id] = 1'b1;
            pipe_a  = req_a[32'(grant_id)*WIDTH +: WIDTH];
            pipe_b  = req_b[32'(grant_id)*WIDTH +: WIDTH];
            pipe_op = req_op[32'(grant_id)*4 +: 4];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started <= 1'b0;
            rr_ptr  <= '0;
        end else begin
            started <= 1'b1;
            if (issue) rr_ptr <= (grant_id == ID_W'(NUM_REQ-1)) ? '0 : grant_id + 1'b1;
        end
    end

    // Tag pipe mirrors the fp pipe; clearing it on reset drops results of pre-reset ops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < LATENCY; i++) tag_q[i] <= '0;
        end else begin
            tag_q[0] <= rsp_tag_t'{valid: issue, id: TAG_ID_W'(grant_id),
                                   err: issue && !op_legal(pipe_op)};
            for (int unsigned i = 1; i < LATENCY; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    assign tag_last      = tag_q[LATENCY-1];
    assign unused_tag_id = ^tag_last.id;
    assign push          = tag_last.valid;
    assign push_data     = {ID_W'(tag_last.id), tag_last.err,
                            tag_last.err ? {WIDTH{1'b0}} : pipe_result};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= '0;
        end else begin
            case ({issue, push})
                2'b10:   inflight <= inflight + CNT_W'(1);
                2'b01:   inflight <= inflight - CNT_W'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    fp_rsp_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .ENTRY_W (ENTRY_W)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    assign rsp_valid = !fifo_empty;
    assign pop       = rsp_valid && rsp_ready;
    assign rsp_id    = rsp_valid ? head[ENTRY_W-1 -: ID_W] : '0;
    assign rsp_err   = rsp_valid ? head[WIDTH] : 1'b0;
    assign rsp_data  = rsp_valid ? head[WIDTH-1:0] : '0;
    assign busy      = (inflight != '0) || (fifo_count != '0);

endmodule
